exe_stage_mul: RTL and testbench
================================

Name: exe_stage_mul

Overview:
- Execute stage of the ARM pipeline.
- Consumes the ID/EX register outputs and computes:
  - Val2: immediate rotate, register shift, or memory offset.
  - ALU result.
  - Branch target.
- Holds the NZCV status register.
- Adds an iterative multi-cycle MUL unit that stalls the front end and bubbles EXE/MEM while busy.

Parameters:
- RADIX_BITS, 4: multiplier bits retired per iteration; legal values 1, 2, 4, 8. Iterations N = 32/RADIX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in  in  1 each  control from ID/EX register
- exe_cmd_in  in  4  ALU command
- dest_in  in  4  destination register
- sr_in  in  4  NZCV snapshot captured at decode
- shift_operand_in  in  12  shifter operand
- imm_signed_24_in  in  24  branch offset
- PC_in, value_rn_in, value_rm_in  in  32 each  PC+4, Rn, Rm
- wb_en, mem_r_en, mem_w_en  out  1 each  to EXE/MEM register
- dest  out  4  to EXE/MEM register
- alu_result  out  32  ALU/product
- value_rm  out  32  store data
- br_taken  out  1  branch taken
- br_addr  out  32  branch target
- status  out  4  current NZCV, fed to the condition checker
- stall  out  1  freezes IF, IF/ID and ID/EX

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, status=0, multiplier registers=0.
  - All outputs are combinational from inputs/state; in IDLE with all-zero inputs they are 0.
- Val2:
  - imm_in=1: zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8].
  - mem_r_en_in|mem_w_en_in with imm_in=0: zero-extended shift_operand[11:0].
  - Otherwise: value_rm_in shifted by shift_operand[11:7] using type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- exe_cmd encoding:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB: Rn-Val2
  - 0101 SBC: Rn-Val2-~C
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - 1010 MUL: Rn*Rm, low 32 bits
  - 0000 NOP: result 0, no flag update
- Carry source: C for ADC/SBC comes from sr_in[1].
- Flags: N=result[31], Z=(result==0).
  - C: carry-out of the 33-bit add/sub; for SUB/SBC it is NOT-borrow.
  - V: signed overflow.
  - Logical ops and MUL leave C and V unchanged.
- br_taken=b_in; br_addr=PC_in + (sign_extend(imm_signed_24_in)<<2), computed in 32-bit wrap-around arithmetic.
- status updates at the posedge when s_in=1 and stall=0.
  - A MUL updates it only on its DONE cycle.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE, exe_cmd_in=1010: latch Rn (multiplicand) and Rm (multiplier); clear accumulator; count=N; stall=1; next BUSY.
  - BUSY, each cycle: acc += (multiplicand * multiplier[RADIX_BITS-1:0]); multiplicand <<= RADIX_BITS; multiplier >>= RADIX_BITS; count-1. stall=1. When count reaches 1, next DONE.
  - DONE: stall=0; alu_result=acc; wb_en/dest pass through; next IDLE.
  - ID/EX is held by stall, so the MUL is still on the inputs in DONE. It must not re-trigger; DONE always returns to IDLE.
- While stall=1: wb_en=mem_r_en=mem_w_en=0 and br_taken=0 (bubble downstream).
- Occupancy: MUL occupies N+2 cycles (10 at default).
- Back-to-back MULs: the second is accepted in the IDLE cycle right after DONE.
- rst during BUSY/DONE: abort to IDLE, stall=0 on the next cycle, status=0.

Optional Feature:
- MUL_EARLY_EXIT_EN defined: in BUSY, when the remaining multiplier bits are all 0, go to DONE next cycle. Minimum occupancy 2 cycles (IDLE→DONE directly when Rm==0).
- Not defined: fixed N+2 cycles regardless of operands.

Test Plan:
- ADD Rn=0x7FFFFFFF, Val2=imm 1, s=1 -> alu_result=0x80000000; status N=1 Z=0 C=0 V=1 after posedge.
- SUB Rn=5, Rm=5 (LSL 0), s=1 -> result 0; Z=1, C=1. Then ADC Rn=1, imm 1 with sr_in=0010 -> result 3.
- MOV imm shift_operand=0x4FF -> Val2=0xFF000000. LDR, imm_in=0, offset 0xFFF -> alu_result=Rn+0xFFF.
- B with PC_in=0x100, imm24=0xFFFFFE -> br_taken=1, br_addr=0xF8.
- MUL Rn=0x12345678, Rm=0x10, RADIX_BITS=4, s=1 -> stall high 9 cycles, wb_en=0 during them. DONE: alu_result=0x23456780, wb_en=1; C,V unchanged. Without the macro, no retrigger on the next cycle.
- MUL with rst asserted in the 3rd BUSY cycle -> IDLE, stall=0 next cycle, status=0. With MUL_EARLY_EXIT_EN and Rm=0: DONE one cycle after acceptance, result 0, Z=1.

Source files
------------

// File: rtl/exe_stage_mul_if.sv
// ID/EX-to-execute bundle: decoded instruction fields in, EXE/MEM fields, branch and stall out.
interface exe_stage_mul_if;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        b_in;
  logic        s_in;
  logic        imm_in;
  logic [3:0]  exe_cmd_in;
  logic [3:0]  dest_in;
  logic [3:0]  sr_in;
  logic [11:0] shift_operand_in;
  logic [23:0] imm_signed_24_in;
  logic [31:0] PC_in;
  logic [31:0] value_rn_in;
  logic [31:0] value_rm_in;

  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] value_rm;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [3:0]  status;
  logic        stall;

  modport master (
    output wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
           dest_in, sr_in, shift_operand_in, imm_signed_24_in, PC_in,
           value_rn_in, value_rm_in,
    input  wb_en, mem_r_en, mem_w_en, dest, alu_result, value_rm, br_taken,
           br_addr, status, stall
  );

  modport slave (
    input  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
           dest_in, sr_in, shift_operand_in, imm_signed_24_in, PC_in,
           value_rn_in, value_rm_in,
    output wb_en, mem_r_en, mem_w_en, dest, alu_result, value_rm, br_taken,
           br_addr, status, stall
  );
endinterface

// File: rtl/exe_stage_mul.sv
// ARM execute stage: combinational shifter/ALU/branch, NZCV register, iterative MUL (N+2 cycles,
// stalls front end and bubbles downstream). MUL_EARLY_EXIT_EN ends the MUL once multiplier bits run out.
module exe_stage_mul #(
  parameter int RADIX_BITS = 4
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mul_if.slave bus
);
  localparam int N = 32 / RADIX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [5:0]  count;
  logic [3:0]  status_q;

  logic        is_mul;
  logic        stall_c;
  logic [31:0] digit;

  assign is_mul  = (bus.exe_cmd_in == 4'b1010);
  assign stall_c = ((state == IDLE) && is_mul) || (state == BUSY);
  assign digit   = {{(32-RADIX_BITS){1'b0}}, mplier[RADIX_BITS-1:0]};

  logic [31:0] val2;
  logic [31:0] imm_ext;
  logic [4:0]  rot;
  logic [4:0]  sh_amt;
  logic [63:0] imm_dbl;
  logic [63:0] rm_dbl;

  always_comb begin
    imm_ext = {24'b0, bus.shift_operand_in[7:0]};
    rot     = {bus.shift_operand_in[11:8], 1'b0};
    imm_dbl = {imm_ext, imm_ext} >> rot;
    sh_amt  = bus.shift_operand_in[11:7];
    rm_dbl  = {bus.value_rm_in, bus.value_rm_in} >> sh_amt;
    val2    = '0;
    if (bus.imm_in) begin
      val2 = imm_dbl[31:0];
    end else if (bus.mem_r_en_in || bus.mem_w_en_in) begin
      val2 = {20'b0, bus.shift_operand_in};
    end else begin
      case (bus.shift_operand_in[6:5])
        2'b00:   val2 = bus.value_rm_in << sh_amt;
        2'b01:   val2 = bus.value_rm_in >> sh_amt;
        2'b10:   val2 = $signed(bus.value_rm_in) >>> sh_amt;
        default: val2 = rm_dbl[31:0];
      endcase
    end
  end

  logic [32:0] sum;
  logic [31:0] result;
  logic        c_new;
  logic        v_new;
  logic        flag_upd;
  logic        c_in;

  assign c_in = bus.sr_in[1];

  // Subtraction is Rn + ~Val2 + 1 so bit 32 is directly the ARM NOT-borrow carry.
  always_comb begin
    sum      = '0;
    result   = '0;
    c_new    = status_q[1];
    v_new    = status_q[0];
    flag_upd = 1'b1;
    case (bus.exe_cmd_in)
      4'b0001: result = val2;
      4'b1001: result = ~val2;
      4'b0010, 4'b0011: begin
        sum    = {1'b0, bus.value_rn_in} + {1'b0, val2}
                 + {32'b0, (bus.exe_cmd_in[0] & c_in)};
        result = sum[31:0];
        c_new  = sum[32];
        v_new  = (bus.value_rn_in[31] == val2[31]) && (result[31] != bus.value_rn_in[31]);
      end
      4'b0100, 4'b0101: begin
        sum    = {1'b0, bus.value_rn_in} + {1'b0, ~val2}
                 + {32'b0, (bus.exe_cmd_in[0] ? c_in : 1'b1)};
        result = sum[31:0];
        c_new  = sum[32];
        v_new  = (bus.value_rn_in[31] != val2[31]) && (result[31] != bus.value_rn_in[31]);
      end
      4'b0110: result = bus.value_rn_in & val2;
      4'b0111: result = bus.value_rn_in | val2;
      4'b1000: result = bus.value_rn_in ^ val2;
      4'b1010: result = acc;
      default: flag_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      status_q <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      // A MUL only reaches here unstalled in DONE, so its flags come from the final product.
      if (bus.s_in && !stall_c && flag_upd)
        status_q <= {result[31], (result == 32'd0), c_new, v_new};
      case (state)
        IDLE: begin
          if (is_mul) begin
            mcand  <= bus.value_rn_in;
            mplier <= bus.value_rm_in;
            acc    <= '0;
            count  <= 6'(N);
            state  <= BUSY;
`ifdef MUL_EARLY_EXIT_EN
            if (bus.value_rm_in == 32'd0) state <= DONE;
`endif
          end
        end
        BUSY: begin
          acc    <= acc + mcand * digit;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          count  <= count - 6'd1;
          if (count == 6'd1) state <= DONE;
`ifdef MUL_EARLY_EXIT_EN
          if ((mplier >> RADIX_BITS) == 32'd0) state <= DONE;
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_en      = bus.wb_en_in & ~stall_c;
  assign bus.mem_r_en   = bus.mem_r_en_in & ~stall_c;
  assign bus.mem_w_en   = bus.mem_w_en_in & ~stall_c;
  assign bus.dest       = bus.dest_in;
  assign bus.alu_result = result;
  assign bus.value_rm   = bus.value_rm_in;
  assign bus.br_taken   = bus.b_in & ~stall_c;
  assign bus.br_addr    = bus.PC_in + {{6{bus.imm_signed_24_in[23]}}, bus.imm_signed_24_in, 2'b00};
  assign bus.status     = status_q;
  assign bus.stall      = stall_c;
endmodule

// File: tb/tb_exe_stage_mul.sv
// Directed-vector bench for exe_stage_mul with hand-computed expectations.
module tb_exe_stage_mul;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   bubble_bad;

  exe_stage_mul_if bus();

  exe_stage_mul #(.RADIX_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUL_EARLY_EXIT_EN
  localparam int STALL_0X10 = 3;
  localparam int STALL_3X5  = 2;
  localparam int STALL_RM0  = 1;
`else
  localparam int STALL_0X10 = 9;
  localparam int STALL_3X5  = 9;
  localparam int STALL_RM0  = 9;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0; bus.b_in = 0;
    bus.s_in = 0; bus.imm_in = 0; bus.exe_cmd_in = 4'b0000; bus.dest_in = 4'd0;
    bus.sr_in = 4'd0; bus.shift_operand_in = 12'd0; bus.imm_signed_24_in = 24'd0;
    bus.PC_in = 32'd0; bus.value_rn_in = 32'd0; bus.value_rm_in = 32'd0;
  endtask

  task automatic alu_op(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                        input logic [31:0] rn, input logic [31:0] rm, input logic s);
    clear_in();
    bus.exe_cmd_in = cmd; bus.imm_in = imm; bus.shift_operand_in = so;
    bus.value_rn_in = rn; bus.value_rm_in = rm; bus.s_in = s; bus.wb_en_in = 1;
    #1;
  endtask

  // Drives a MUL, counts stalled cycles (bounded), leaves the DUT in its DONE cycle.
  task automatic run_mul(input string tag, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] exp, input int exp_stall);
    int n;
    alu_op(4'b1010, 1'b0, 12'd0, rn, rm, 1'b1);
    bus.dest_in = 4'd3;
    #1;
    n = 0;
    while (bus.stall && n < 64) begin
      if (bus.wb_en || bus.br_taken || bus.mem_r_en) bubble_bad++;
      n++;
      tick();
    end
    chk({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, " result"}, bus.alu_result, exp);
    chk({tag, " done wb_en"}, 32'(bus.wb_en), 32'd1);
    chk({tag, " done dest"}, 32'(bus.dest), 32'd3);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; bubble_bad = 0;
    clear_in();
    rst = 1'b1;
    tick(); tick();
    chk("reset status", 32'(bus.status), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset alu_result", bus.alu_result, 32'd0);
    chk("reset br_addr", bus.br_addr, 32'd0);
    rst = 1'b0;
    tick();

    alu_op(4'b0010, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0, 1'b1);
    chk("add result", bus.alu_result, 32'h8000_0000);
    chk("add wb_en", 32'(bus.wb_en), 32'd1);
    tick();
    chk("add nzcv", 32'(bus.status), 32'b1001);

    alu_op(4'b0100, 1'b0, 12'h000, 32'd5, 32'd5, 1'b1);
    chk("sub result", bus.alu_result, 32'd0);
    tick();
    chk("sub nzcv", 32'(bus.status), 32'b0110);

    alu_op(4'b0011, 1'b1, 12'h001, 32'd1, 32'd0, 1'b0);
    bus.sr_in = 4'b0010;
    #1;
    chk("adc result", bus.alu_result, 32'd3);
    tick();
    chk("s=0 keeps nzcv", 32'(bus.status), 32'b0110);

    alu_op(4'b0000, 1'b1, 12'h0FF, 32'd9, 32'd0, 1'b1);
    chk("nop result", bus.alu_result, 32'd0);
    tick();
    chk("nop keeps nzcv", 32'(bus.status), 32'b0110);

    alu_op(4'b0001, 1'b1, 12'h4FF, 32'd0, 32'd0, 1'b0);
    chk("mov rot imm", bus.alu_result, 32'hFF00_0000);

    alu_op(4'b0001, 1'b0, 12'h240, 32'd0, 32'h8000_0000, 1'b0);
    chk("mov asr 4", bus.alu_result, 32'hF800_0000);

    alu_op(4'b0010, 1'b0, 12'hFFF, 32'h0000_1000, 32'h1234_5678, 1'b0);
    bus.mem_r_en_in = 1;
    #1;
    chk("ldr offset", bus.alu_result, 32'h0000_1FFF);
    chk("ldr mem_r_en", 32'(bus.mem_r_en), 32'd1);

    clear_in();
    bus.b_in = 1; bus.PC_in = 32'h100; bus.imm_signed_24_in = 24'hFFFFFE;
    #1;
    chk("branch taken", 32'(bus.br_taken), 32'd1);
    chk("branch addr", bus.br_addr, 32'h0000_00F8);
    tick();

    alu_op(4'b0010, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0, 1'b1);
    tick();
    chk("pre-mul nzcv", 32'(bus.status), 32'b1001);

    run_mul("mul 0x12345678*0x10", 32'h1234_5678, 32'h10, 32'h2345_6780, STALL_0X10);
    chk("mul nzcv before done edge", 32'(bus.status), 32'b1001);
    tick();
    chk("mul nzcv after done", 32'(bus.status), 32'b0001);
    // Next MUL already on the inputs right after DONE: accepted in this IDLE cycle.
    run_mul("mul back-to-back 3*5", 32'd3, 32'd5, 32'd15, STALL_3X5);
    tick();
    clear_in();
    #1;
    chk("no retrigger after done", 32'(bus.stall), 32'd0);
    chk("bubbles while stalled", 32'(bubble_bad), 32'd0);

    alu_op(4'b1010, 1'b0, 12'd0, 32'd7, 32'hFFFF_0000, 1'b1);
    tick(); tick(); tick();
    chk("mul busy stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_in();
    #1;
    chk("rst abort stall", 32'(bus.stall), 32'd0);
    chk("rst abort nzcv", 32'(bus.status), 32'd0);
    tick();

    run_mul("mul rm=0", 32'd5, 32'd0, 32'd0, STALL_RM0);
    tick();
    chk("mul rm=0 nzcv", 32'(bus.status), 32'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
